// File: rtl/priority_code_decoder_if.sv
// Handshake and output bundle between the encoder link and the priority code decoder.
// The master drives codes and error clears; the slave returns readiness and line strobes.
interface priority_code_decoder_if;
  logic [7:0]  code_in;
  logic        code_valid;
  logic        clr_err;
  logic        code_ready;
  logic [15:0] onehot_out;
  logic        active;
  logic        none_pulse;
  logic        err_illegal;

  modport master (
    output code_in,
    output code_valid,
    output clr_err,
    input  code_ready,
    input  onehot_out,
    input  active,
    input  none_pulse,
    input  err_illegal
  );

  modport slave (
    input  code_in,
    input  code_valid,
    input  clr_err,
    output code_ready,
    output onehot_out,
    output active,
    output none_pulse,
    output err_illegal
  );
endinterface

// File: rtl/priority_code_decoder.sv
// Priority code decoder: turns an 8-bit encoder code back into a one-hot 16-line strobe.
// A decoded line is held for HOLD_CYCLES cycles; the "none" code pulses none_pulse and any
// other non-line code sets a sticky error flag. Only IDLE accepts codes.
module priority_code_decoder #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  priority_code_decoder_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] CODE_NONE = 8'hF0;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_onehot;
  logic        r_active;
  logic        r_none;
  logic        r_err;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] w_onehot_nxt;
  logic        w_active_nxt;
  logic        w_none_nxt;
  logic        w_err_nxt;
  logic        w_accept;
  logic        w_is_line;
  logic        w_is_none;
  logic        w_is_illegal;

  assign w_accept     = bus.code_valid && (r_state == ST_IDLE);
  assign w_is_line    = (bus.code_in[7:4] == 4'h0);
  assign w_is_none    = (bus.code_in == CODE_NONE);
  assign w_is_illegal = !w_is_line && !w_is_none;

  // State register; reset returns to IDLE so the block is ready immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, hold counter and output next values for both states.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = r_onehot;
    w_active_nxt = r_active;
    w_none_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_is_line) begin
          w_onehot_nxt = 16'h0001 << bus.code_in[3:0];
          w_active_nxt = 1'b1;
          w_cnt_nxt    = HOLD_LOAD;
          w_state_nxt  = ST_HOLD;
        end else if (w_accept && w_is_none) begin
          w_none_nxt   = 1'b1;
        end else begin
          w_onehot_nxt = 16'h0000;
          w_active_nxt = 1'b0;
        end
      end
      ST_HOLD: begin
        if (r_cnt != 8'd0) begin
          w_cnt_nxt    = r_cnt - 8'd1;
        end else begin
          w_onehot_nxt = 16'h0000;
          w_active_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_cnt_nxt    = 8'd0;
        w_onehot_nxt = 16'h0000;
        w_active_nxt = 1'b0;
      end
    endcase
  end

  // Sticky error: an accepted illegal code beats a simultaneous clear.
  always_comb begin
    if (w_accept && w_is_illegal) begin
      w_err_nxt = 1'b1;
    end else if (bus.clr_err) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err;
    end
  end

  // Registered datapath: counter and all line/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 8'd0;
      r_onehot <= 16'h0000;
      r_active <= 1'b0;
      r_none   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_active <= w_active_nxt;
      r_none   <= w_none_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.code_ready  = (r_state == ST_IDLE);
  assign bus.onehot_out  = r_onehot;
  assign bus.active      = r_active;
  assign bus.none_pulse  = r_none;
  assign bus.err_illegal = r_err;

endmodule

// File: tb/tb_priority_code_decoder.sv
// Self-checking bench for priority_code_decoder: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance,
// a per-cycle vector table with a scoreboard queue, and hand-written reset sequences.
module tb_priority_code_decoder;

  logic clk;
  logic rst;

  priority_code_decoder_if if4 ();
  priority_code_decoder_if if1 ();

  priority_code_decoder #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  priority_code_decoder #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    bit          sel;   // 0: HOLD=4 instance, 1: HOLD=1 instance
    logic [7:0]  code;
    logic        valid;
    logic        clr;
    logic [15:0] oh;
    logic        act;
    logic        none;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t vec_q[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input bit sel, input logic [7:0] code, input logic valid, input logic clr,
                     input logic [15:0] oh, input logic act, input logic none, input logic err,
                     input logic rdy);
    vec_t v;
    v.sel = sel; v.code = code; v.valid = valid; v.clr = clr;
    v.oh = oh; v.act = act; v.none = none; v.err = err; v.rdy = rdy;
    vec_q.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input bit sel, input vec_t e);
    logic [15:0] oh;
    logic act, none, err, rdy;
    if (sel) begin
      oh = if1.onehot_out; act = if1.active; none = if1.none_pulse;
      err = if1.err_illegal; rdy = if1.code_ready;
    end else begin
      oh = if4.onehot_out; act = if4.active; none = if4.none_pulse;
      err = if4.err_illegal; rdy = if4.code_ready;
    end
    chk({tag, " onehot"}, oh, e.oh);
    chk({tag, " active"}, {15'd0, act}, {15'd0, e.act});
    chk({tag, " none"}, {15'd0, none}, {15'd0, e.none});
    chk({tag, " err"}, {15'd0, err}, {15'd0, e.err});
    chk({tag, " ready"}, {15'd0, rdy}, {15'd0, e.rdy});
  endtask

  // Drive one cycle of stimulus, push its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clk);
    if4.code_in = 8'h00; if4.code_valid = 1'b0; if4.clr_err = 1'b0;
    if1.code_in = 8'h00; if1.code_valid = 1'b0; if1.clr_err = 1'b0;
    if (v.sel) begin
      if1.code_in = v.code; if1.code_valid = v.valid; if1.clr_err = v.clr;
    end else begin
      if4.code_in = v.code; if4.code_valid = v.valid; if4.clr_err = v.clr;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(tag, e.sel, e);
  endtask

  task automatic add_hold4_line(input logic [7:0] code, input logic [15:0] oh);
    add(1'b0, code, 1'b1, 1'b0, oh, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, 1'b0, oh, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    vec_t v;
    vec_t rz;

    // ---- vector table ----
    add_hold4_line(8'h05, 16'h0020);
    add_hold4_line(8'h0F, 16'h8000);
    add_hold4_line(8'h00, 16'h0001);
    // busy ignore: 0A held valid through the 03 hold window, accepted at N+5
    add(1'b0, 8'h03, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h0A, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h0A, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h0A, 1'b1, 1'b0, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0400, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    // none code three edges in a row
    for (int i = 0; i < 3; i++) add(1'b0, 8'hF0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    // illegal code, sticky, clear, set-wins-over-clear
    add(1'b0, 8'h23, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h10, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'hF0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 8'hFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    // HOLD_CYCLES=1: one cycle high, re-accept two edges after the first
    add(1'b1, 8'h02, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h02, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h02, 1'b1, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

    rz.sel = 1'b0; rz.code = 8'h00; rz.valid = 1'b0; rz.clr = 1'b0;
    rz.oh = 16'h0000; rz.act = 1'b0; rz.none = 1'b0; rz.err = 1'b0; rz.rdy = 1'b1;

    // ---- power-on reset ----
    rst = 1'b1;
    if4.code_in = 8'h00; if4.code_valid = 1'b0; if4.clr_err = 1'b0;
    if1.code_in = 8'h00; if1.code_valid = 1'b0; if1.clr_err = 1'b0;
    #12;
    check_outputs("reset4", 1'b0, rz);
    check_outputs("reset1", 1'b1, rz);
    @(negedge clk);
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      step($sformatf("vec%0d", i), v);
    end

    // ---- asynchronous reset in the middle of a hold ----
    v = rz; v.code = 8'h07; v.valid = 1'b1; v.oh = 16'h0080; v.act = 1'b1; v.rdy = 1'b0;
    step("hold07", v);
    v.code = 8'h00; v.valid = 1'b0;
    step("hold07b", v);
    #1;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 1'b0, rz);
    @(negedge clk);
    rst = 1'b0;
    v = rz; v.code = 8'h05; v.valid = 1'b1; v.oh = 16'h0020; v.act = 1'b1; v.rdy = 1'b0;
    step("post_rst_accept", v);
    v.code = 8'h00; v.valid = 1'b0;
    for (int i = 0; i < 3; i++) step("post_rst_hold", v);
    step("post_rst_release", rz);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_code_decoder.md
# priority_code_decoder

Sequential decoder that consumes the 8-bit priority code produced by the team's 16-input priority encoder and regenerates the corresponding one-hot 16-bit line vector.
- Codes 0-15 select a line.
- Code 8'hF0 means "no line active".
- Any other code is illegal.
- Each decoded line is driven for a programmable number of cycles, then released, under a valid/ready handshake.

The block sits on the receiving side of the encoder link and drives downstream per-line strobes.

## Interface
- HOLD_CYCLES, default 4: cycles a decoded line stays asserted; legal range 1..255.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- code_in  input  8  encoder code: 8'h00-8'h0F line index, 8'hF0 none, else illegal.
- code_valid  input  1  code_in is valid this cycle.
- code_ready  output  1  block can accept a code; high exactly when state is IDLE (combinational from state).
- onehot_out  output  16  registered one-hot line vector; bit k is high for code k.
- active  output  1  registered; high while a line is being held.
- none_pulse  output  1  registered; one-cycle pulse on acceptance of 8'hF0.
- err_illegal  output  1  registered, sticky; set on acceptance of an illegal code.
- clr_err  input  1  synchronous clear of err_illegal.

## Operation
- Reset (async, rst=1): state=IDLE, hold counter=0, onehot_out=16'h0000, active=0, none_pulse=0, err_illegal=0. code_ready is then 1.
- Accept: a code is accepted at a rising edge where code_valid=1 and code_ready=1. code_valid while code_ready=0 is ignored; the code is not queued.
- State IDLE, on accept:
  - code_in[7:4]==0: onehot_out <= 1<<code_in[3:0]; active <= 1; counter <= HOLD_CYCLES-1; state -> HOLD.
  - code_in==8'hF0: onehot_out stays 0; none_pulse <= 1 for one cycle; state stays IDLE.
  - any other value: err_illegal <= 1; onehot_out stays 0; state stays IDLE.
- State HOLD, at each edge:
  - counter!=0: counter decrements; onehot_out and active hold.
  - counter==0: onehot_out <= 0, active <= 0, state -> IDLE.
- none_pulse: cleared on every edge that does not accept 8'hF0.
- err_illegal:
  - clr_err=1 clears it at the edge.
  - If an illegal code is accepted at the same edge as clr_err, set wins (err_illegal=1).
  - clr_err has no effect on any other output.
- Counter width: 8 bits; no wrap is possible within the legal HOLD_CYCLES range.
- Invariant: onehot_out is always either zero or exactly one bit set. active == (onehot_out != 0).

## Timing
- Latency: code accepted at edge N; onehot_out and active visible after edge N. Exactly one cycle code-to-output.
- Hold window: a line stays high for exactly HOLD_CYCLES cycles and clears at edge N+HOLD_CYCLES.
  - HOLD_CYCLES=1: counter is loaded with 0, and the line clears at edge N+1.
- code_ready: low from after edge N until after edge N+HOLD_CYCLES.
- Throughput: the earliest next accept is edge N+HOLD_CYCLES+1, giving one line-code per HOLD_CYCLES+1 cycles. There is always at least one idle-output cycle between consecutive lines.
- Codes 8'hF0 and illegal codes do not leave IDLE, so back-to-back accepts every cycle are possible.
- Reset mid-HOLD: all outputs clear immediately (asynchronously), without waiting for a clock edge. The first accept after rst deasserts is allowed at the next rising edge.

## Test plan
- Reset: assert rst mid-simulation with stimulus idle. Required: onehot_out=0, active=0, none_pulse=0, err_illegal=0, code_ready=1, all without a clock edge.
- Basic decode, HOLD_CYCLES=4: send code 8'h05 at edge N. Required:
  - onehot_out=16'h0020 and active=1 for exactly 4 cycles, then 0.
  - code_ready=0 during that window.
  - Repeat with 8'h0F (16'h8000) and 8'h00 (16'h0001).
- Busy ignore: during HOLD of 8'h03, present 8'h0A with code_valid=1 continuously. Required:
  - onehot_out stays 16'h0008 until release.
  - 8'h0A is then accepted at edge N+5, giving 16'h0400.
- None code: send 8'hF0 at three consecutive edges. Required: none_pulse=1 for three cycles, onehot_out=0 throughout, code_ready=1 throughout.
- Illegal and clr_err:
  - Send 8'h23. Required: err_illegal=1 and stays set, onehot_out=0.
  - Pulse clr_err alone. Required: err_illegal clears.
  - Apply clr_err together with accepted code 8'h10. Required: err_illegal=1.
- Reset mid-hold and HOLD_CYCLES=1:
  - rst during HOLD of 8'h07. Required: onehot_out=0 immediately.
  - With HOLD_CYCLES=1, code 8'h02. Required: 16'h0004 for exactly one cycle, next accept possible two edges after the first.
